chunked_seq_adder: RTL

- Multi-cycle, parametrised WIDTH-bit adder/subtractor for the int8 vector MAC datapath.
- Processes CHUNK bits per clock through a registered carry, so one narrow adder is reused across the word.
- Uses a valid/ready handshake on both input and output.
- Successor to the single-bit full-adder cell: adds width generalisation, an add/sub mode, signed-overflow flag and sequential operation.

---
 rtl/chunked_seq_adder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/chunked_seq_adder.sv
// rtl/chunked_seq_adder.sv - multi-cycle chunked WIDTH-bit adder/subtractor with valid/ready handshakes
//
// Purpose: adds (or subtracts) two WIDTH-bit operands CHUNK bits per clock. A
// single CHUNK-bit adder is reused across the word, with the carry held in a
// register between chunks.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand request
//   in_ready   block can accept operands (state IDLE)
//   a, b       operands, sampled only on the accept edge
//   cin        carry-in, used only when sub=0
//   sub        0: a+b+cin, 1: a-b (a+~b+1)
//   out_valid  result available (state DONE)
//   out_ready  consumer accepts result
//   sum        result modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1; for sub, 1 means no borrow
//   ovf        two's-complement signed overflow
//   busy       high in RUN or DONE
module chunked_seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  if (CHUNK < 1 || WIDTH < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("chunked_seq_adder: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK:0]   chunk_sum;

  // The one narrow adder shared by every chunk of the word.
  always_comb begin
    chunk_a   = opa[idx*CHUNK +: CHUNK];
    chunk_b   = opb[idx*CHUNK +: CHUNK];
    chunk_sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
            opb   <= sub ? ~b : b;
            carry <= sub | cin;
            idx   <= '0;
            sum   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[idx*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry                   <= chunk_sum[CHUNK];
          idx                     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= DONE;
            cout  <= chunk_sum[CHUNK];
            // Overflow when both addends share a sign the result does not.
            // opb already holds ~b for sub, so one rule covers add and sub.
            ovf   <= (opa[WIDTH-1] == opb[WIDTH-1]) &&
                     (chunk_sum[CHUNK-1] != opa[WIDTH-1]);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

endmodule
